// File: rtl/csa_subtractor_16bit_pipe.sv
// csa_subtractor_16bit_pipe
// Two-stage pipelined carry-select subtractor: diff = a - b - bin.
// Stage 1 computes the low half and both high-half candidates.
// Stage 2 selects the high half using the low-half carry and produces
// the borrow-out and signed-overflow flags.
// Valid/ready on both sides; full throughput when the consumer is ready.
// Datapath registers load only when a valid item moves into them, so
// diff/bout/ovf keep their last values while out_valid is low.
// WIDTH must be even: the split point is WIDTH/2.

module csa_subtractor_16bit_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int HALF = WIDTH / 2;
  localparam int HW   = WIDTH - HALF;

  // pipeline advance controls
  logic adv1;
  logic adv2;

  // stage 1 combinational results
  logic [HALF:0] lo_sum;
  logic [HW:0]   hi0_sum;
  logic [HW:0]   hi1_sum;

  // stage 1 registers
  logic            s1_v_q,     s1_v_d;
  logic [HALF-1:0] s1_dlo_q,   s1_dlo_d;
  logic            s1_cl_q,    s1_cl_d;
  logic [HW-1:0]   s1_hi0_q,   s1_hi0_d;
  logic            s1_c0_q,    s1_c0_d;
  logic [HW-1:0]   s1_hi1_q,   s1_hi1_d;
  logic            s1_c1_q,    s1_c1_d;
  logic            s1_amsb_q,  s1_amsb_d;
  logic            s1_bmsb_q,  s1_bmsb_d;

  // stage 2 combinational results
  logic [HW-1:0]    hi_sel;
  logic             co_sel;
  logic [WIDTH-1:0] diff_new;
  logic             bout_new;
  logic             ovf_new;

  // output registers
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] diff_q,      diff_d;
  logic             bout_q,      bout_d;
  logic             ovf_q,       ovf_d;

  // handshake: a stage advances when it is empty or the stage after it advances
  always_comb begin
    adv2     = !out_valid_q || out_ready;
    adv1     = !s1_v_q || adv2;
    in_ready = adv1;
  end

  // stage 1 arithmetic: a + ~b + ~bin, high half speculated for both carries
  always_comb begin
    lo_sum  = {1'b0, a[HALF-1:0]} + {1'b0, ~b[HALF-1:0]} + {{HALF{1'b0}}, ~bin};
    hi0_sum = {1'b0, a[WIDTH-1:HALF]} + {1'b0, ~b[WIDTH-1:HALF]};
    hi1_sum = {1'b0, a[WIDTH-1:HALF]} + {1'b0, ~b[WIDTH-1:HALF]} + {{HW{1'b0}}, 1'b1};
  end

  // stage 1 next state: valid follows in_valid on advance, data loads only on a real transfer
  always_comb begin
    s1_v_d    = s1_v_q;
    s1_dlo_d  = s1_dlo_q;
    s1_cl_d   = s1_cl_q;
    s1_hi0_d  = s1_hi0_q;
    s1_c0_d   = s1_c0_q;
    s1_hi1_d  = s1_hi1_q;
    s1_c1_d   = s1_c1_q;
    s1_amsb_d = s1_amsb_q;
    s1_bmsb_d = s1_bmsb_q;
    if (adv1) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        s1_dlo_d  = lo_sum[HALF-1:0];
        s1_cl_d   = lo_sum[HALF];
        s1_hi0_d  = hi0_sum[HW-1:0];
        s1_c0_d   = hi0_sum[HW];
        s1_hi1_d  = hi1_sum[HW-1:0];
        s1_c1_d   = hi1_sum[HW];
        s1_amsb_d = a[WIDTH-1];
        s1_bmsb_d = b[WIDTH-1];
      end
    end
  end

  // stage 1 registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_dlo_q  <= '0;
      s1_cl_q   <= 1'b0;
      s1_hi0_q  <= '0;
      s1_c0_q   <= 1'b0;
      s1_hi1_q  <= '0;
      s1_c1_q   <= 1'b0;
      s1_amsb_q <= 1'b0;
      s1_bmsb_q <= 1'b0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_dlo_q  <= s1_dlo_d;
      s1_cl_q   <= s1_cl_d;
      s1_hi0_q  <= s1_hi0_d;
      s1_c0_q   <= s1_c0_d;
      s1_hi1_q  <= s1_hi1_d;
      s1_c1_q   <= s1_c1_d;
      s1_amsb_q <= s1_amsb_d;
      s1_bmsb_q <= s1_bmsb_d;
    end
  end

  // stage 2 select: the low-half carry picks the high-half candidate and final carry
  always_comb begin
    hi_sel   = s1_cl_q ? s1_hi1_q : s1_hi0_q;
    co_sel   = s1_cl_q ? s1_c1_q  : s1_c0_q;
    diff_new = {hi_sel, s1_dlo_q};
    bout_new = ~co_sel;
    ovf_new  = (s1_amsb_q != s1_bmsb_q) && (diff_new[WIDTH-1] != s1_amsb_q);
  end

  // output next state: hold everything while stalled, load data only for a valid item
  always_comb begin
    out_valid_d = out_valid_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    ovf_d       = ovf_q;
    if (adv2) begin
      out_valid_d = s1_v_q;
      if (s1_v_q) begin
        diff_d = diff_new;
        bout_d = bout_new;
        ovf_d  = ovf_new;
      end
    end
  end

  // output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      ovf_q       <= ovf_d;
    end
  end

  // output port drive
  always_comb begin
    out_valid = out_valid_q;
    diff      = diff_q;
    bout      = bout_q;
    ovf       = ovf_q;
  end

endmodule

// File: doc/csa_subtractor_16bit_pipe.md
Name: csa_subtractor_16bit_pipe

Overview:
- 2-stage pipelined 16-bit carry-select subtractor: diff = a - b - bin, with borrow-out and signed-overflow flags.
- Inverse-direction companion to the team's 16-bit carry-select adder.
- Uses valid/ready handshakes on both sides so it can sit between stream producers and consumers in the arithmetic datapath.
- Full throughput: one result per cycle when unstalled.

Parameters:
- WIDTH, 16, operand width; must be even. The split point is WIDTH/2.
- HALF, WIDTH/2, derived local value: low/high split point. Not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  a/b/bin valid
- in_ready  output  1  block can accept the input this cycle
- a  input  WIDTH  minuend (unsigned or two's complement)
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  diff/bout/ovf valid
- out_ready  input  1  consumer accepts the output this cycle
- diff  output  WIDTH  (a - b - bin) mod 2^WIDTH
- bout  output  1  borrow-out: 1 iff a < b + bin, unsigned
- ovf  output  1  signed overflow: (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB])

Behaviour:
- Arithmetic:
  - Computed as a + ~b + ~bin.
  - Internal carry-out c = ~bout.
  - All values are exact modulo 2^WIDTH.
- Stage 1 (register s1, valid flag s1_v):
  - Low half: dlo = a[HALF-1:0] + ~b[HALF-1:0] + ~bin, with carry cl.
  - High half: both candidates computed in parallel:
    - hi0 = a_hi + ~b_hi + 0, with carry c0
    - hi1 = a_hi + ~b_hi + 1, with carry c1
  - Registered: dlo, cl, hi0, c0, hi1, c1, a[MSB], b[MSB].
- Stage 2 (output registers, valid flag out_valid):
  - Select the high half with cl: diff_hi = cl ? hi1 : hi0.
  - bout = ~(cl ? c1 : c0).
  - ovf computed from the selected diff[MSB] and the registered sign bits.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - adv2 = !out_valid || out_ready
  - adv1 = !s1_v || adv2
  - in_ready = adv1 (combinational, no registered skid).
  - s1 loads on adv1: s1_v <= in_valid.
  - Output registers load on adv2: out_valid <= s1_v.
- Latency:
  - Input accepted at edge N → out_valid high after edge N+1, provided out_ready was not blocking.
  - Unstalled throughput: 1 result per cycle.
- Stall:
  - While out_valid && !out_ready: diff/bout/ovf are held bit-stable.
  - If s1_v is also set, s1 holds and in_ready = 0.
  - Capacity: 2 results in flight.
- Simultaneous events:
  - Output pop and input push in the same cycle with a full pipe: all stages shift; no loss, no duplication.
- Data when invalid:
  - When out_valid = 0, diff/bout/ovf hold their last values.
  - Consumers must qualify on out_valid.
- Reset (asynchronous; also valid mid-operation):
  - s1_v = 0, out_valid = 0.
  - diff = 0, bout = 0, ovf = 0.
  - All s1 data registers = 0.
  - In-flight results are discarded.
  - in_ready = 1 immediately while rst is high and after release.
- Boundaries:
  - a = b, bin = 0 → diff 0, bout 0.
  - a = 0, b = 0, bin = 1 → all ones, bout 1.
  - Borrow crossing the HALF boundary must resolve through cl.

Test Plan:
- Reset then idle: rst pulse with clocks running → out_valid = 0, diff = 0, bout = 0, ovf = 0, in_ready = 1.
- Basic, out_ready = 1, one input per cycle:
  - a=0, b=0, bin=0 → diff=0, bout=0, ovf=0
  - a=0, b=0, bin=1 → diff=0xFFFF, bout=1, ovf=0
  - a=14, b=1, bin=1 → diff=12, bout=0
  - a=999, b=0, bin=1 → diff=998
  - Results appear on consecutive cycles, each 2 edges after its input.
- Half-boundary borrow and overflow:
  - a=0x0100, b=0x0001, bin=0 → diff=0x00FF, bout=0, ovf=0
  - a=0x8000, b=1, bin=0 → diff=0x7FFF, bout=0, ovf=1
  - a=1, b=2, bin=0 → diff=0xFFFF, bout=1, ovf=0
- Backpressure:
  - Setup: out_ready=0, offer 3 back-to-back inputs (5-1, 7-2, 9-3, bin=0).
  - Expected: the first two are accepted, then in_ready=0; diff=4 is held stable for 3 cycles.
  - Then raise out_ready → outputs 4, 5, 6 in order, with no duplicates.
- Reset mid-operation: with 2 results in flight, assert rst asynchronously between edges → out_valid drops immediately, diff=0, the next accepted input (3-1) yields diff=2 only.
- Random regression: 1000 random a/b/bin with random out_ready toggling → each transferred output equals the reference model a - b - bin with correct bout/ovf, in order, none lost.
